// File: rtl/cvita_uart_host.sv
// Host-side peer of the CVITA UART endpoint: wraps tx bytes into 2-beat CHDR command
// packets and unwraps returning context packets into a byte stream with seq checking.
module cvita_uart_host #(
   parameter logic [31:0] SID = 32'h0000_0010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] clkdiv,
   input  logic [7:0]  tx_tdata,
   input  logic        tx_tvalid,
   output logic        tx_tready,
   output logic [63:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   input  logic [63:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [7:0]  rx_tdata,
   output logic        rx_tvalid,
   input  logic        rx_tready,
   output logic        seq_err
);

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_HDR  = 2'd1;
   localparam logic [1:0] T_BODY = 2'd2;

   localparam logic [1:0] R_HDR  = 2'd0;
   localparam logic [1:0] R_TIME = 2'd1;
   localparam logic [1:0] R_BODY = 2'd2;
   localparam logic [1:0] R_DROP = 2'd3;

   logic [1:0]  tx_state;
   logic [11:0] tx_seq;
   logic [7:0]  char_q;
   logic [15:0] clkdiv_q;

   logic [1:0]  rx_state;
   logic [11:0] exp_seq;
   logic [11:0] hdr_seq;
   logic        i_hs;

   // Only the seqnum, has-time flag and payload byte matter on the return path.
   logic        unused_ctx_bits;
   assign unused_ctx_bits = ^{i_tdata[63:62], i_tdata[60], i_tdata[47:8]};

   assign hdr_seq = i_tdata[59:48];
   assign i_hs    = i_tvalid && i_tready;

   // ---------------- TX path ----------------
   // NOTE: every output gets a default before the case so no latch is inferred;
   // gating the readies with rst_n keeps all outputs at 0 while reset is held.
   always_comb begin
      tx_tready = 1'b0;
      o_tvalid  = 1'b0;
      o_tlast   = 1'b0;
      o_tdata   = 64'd0;
      case (tx_state)
         T_IDLE: tx_tready = rst_n;
         T_HDR: begin
            o_tvalid = 1'b1;
            o_tdata  = {2'b00, 1'b0, 1'b0, tx_seq, 16'd16, SID};
         end
         T_BODY: begin
            o_tvalid = 1'b1;
            o_tlast  = 1'b1;
            o_tdata  = {16'h0000, clkdiv_q, 24'h00_0000, char_q};
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= T_IDLE;
         tx_seq   <= 12'd0;
         char_q   <= 8'd0;
         clkdiv_q <= 16'd0;
      end else begin
         case (tx_state)
            T_IDLE: if (tx_tvalid && tx_tready) begin
               char_q   <= tx_tdata;
               clkdiv_q <= clkdiv;
               tx_state <= T_HDR;
            end
            T_HDR:  if (o_tready) tx_state <= T_BODY;
            T_BODY: if (o_tready) begin
               tx_seq   <= tx_seq + 12'd1;
               tx_state <= T_IDLE;
            end
            default: tx_state <= T_IDLE;
         endcase
      end
   end

   // ---------------- RX path ----------------
   // Only a body beat needs a free output slot; every other beat is always taken.
   assign i_tready = rst_n && !(rx_state == R_BODY && rx_tvalid && !rx_tready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state  <= R_HDR;
         exp_seq   <= 12'd0;
         rx_tdata  <= 8'd0;
         rx_tvalid <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         seq_err <= 1'b0;
         if (rx_tvalid && rx_tready) rx_tvalid <= 1'b0;
         if (i_hs) begin
            case (rx_state)
               R_HDR: begin
                  if (hdr_seq == exp_seq) begin
                     exp_seq <= exp_seq + 12'd1;
                  end else begin
                     seq_err <= 1'b1;
                     exp_seq <= hdr_seq + 12'd1;
                  end
                  if (i_tlast)         rx_state <= R_HDR;
                  else if (i_tdata[61]) rx_state <= R_TIME;
                  else                 rx_state <= R_BODY;
               end
               R_TIME: rx_state <= i_tlast ? R_HDR : R_BODY;
               R_BODY: begin
                  // A new byte loading on the same edge as a consume keeps rx_tvalid high.
                  rx_tdata  <= i_tdata[7:0];
                  rx_tvalid <= 1'b1;
                  rx_state  <= i_tlast ? R_HDR : R_DROP;
               end
               R_DROP: if (i_tlast) rx_state <= R_HDR;
               default: rx_state <= R_HDR;
            endcase
         end
      end
   end

endmodule
